spi_fl_sequencer: RTL and testbench

// Sits between two command requesters (port 0 = CPU register path, port 1 = boot/read path) and one spi_master_fl instance.
// - Arbitrates the two ports round-robin.
// - Drives the master's level-valid / tready handshake.
// - Optionally prefixes Write Enable (0x06) to a request.
// - Optionally polls Read Status (0x05) until WIP clears.

---
 rtl/spi_fl_sequencer_if.sv | 39 +++
 rtl/spi_fl_sequencer.sv | 246 ++++++++++++++++++++++++
 tb/tb_spi_fl_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_fl_sequencer_if.sv
// Request/response and spi_master_fl bus bundle for spi_fl_sequencer.
// The slave modport is the sequencer's view; the master modport is the environment's view.
interface spi_fl_sequencer_if;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [15:0] req_cmd;
    logic [5:0]  req_ctyp;
    logic [63:0] req_addr;
    logic [63:0] req_data;
    logic [13:0] req_nmiso;
    logic [1:0]  req_wren;
    logic [1:0]  req_poll;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        busy;
    logic [31:0] m_data_in;
    logic [31:0] m_address;
    logic [7:0]  m_command;
    logic [2:0]  m_commtype;
    logic [6:0]  m_nmiso_bits;
    logic        m_validflag;
    logic [31:0] m_data_out;
    logic        m_tready;

    modport slave (
        input  req_valid, req_cmd, req_ctyp, req_addr, req_data, req_nmiso,
               req_wren, req_poll, m_data_out, m_tready,
        output req_ready, rsp_valid, rsp_data, rsp_err, busy,
               m_data_in, m_address, m_command, m_commtype, m_nmiso_bits, m_validflag
    );

    modport master (
        output req_valid, req_cmd, req_ctyp, req_addr, req_data, req_nmiso,
               req_wren, req_poll, m_data_out, m_tready,
        input  req_ready, rsp_valid, rsp_data, rsp_err, busy,
               m_data_in, m_address, m_command, m_commtype, m_nmiso_bits, m_validflag
    );
endinterface

// File: rtl/spi_fl_sequencer.sv
// Two-port round-robin command sequencer in front of spi_master_fl, with optional
// WREN prefix and RDSR busy polling; one response pulse per accepted request.
module spi_fl_sequencer #(
    parameter int unsigned MAX_POLLS = 256,
    parameter int unsigned POLL_GAP  = 16
) (
    input logic               clk,
    input logic               rst_n,
    spi_fl_sequencer_if.slave bus
);

    localparam int unsigned PCW = $clog2(MAX_POLLS + 1);
    localparam int unsigned GCW = $clog2(POLL_GAP + 1);

    localparam logic [7:0] WREN_OP    = 8'h06;
    localparam logic [2:0] WREN_CT    = 3'b000;
    localparam logic [7:0] RDSR_OP    = 8'h05;
    localparam logic [2:0] RDSR_CT    = 3'b001;
    localparam logic [6:0] RDSR_NMISO = 7'd8;
    localparam logic [6:0] RST_NMISO  = 7'd32;

    typedef enum logic [3:0] {
        IDLE, GRANT, WREN_ISS, WREN_WT, CMD_ISS, CMD_WT, GAP, POLL_ISS, POLL_WT, RESP
    } state_e;

    state_e      state_q, state_d;
    logic        prio_q, prio_d;
    logic        port_q, port_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [2:0]  ctyp_q, ctyp_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [6:0]  nmiso_q, nmiso_d;
    logic        wren_q, wren_d;
    logic        poll_q, poll_d;
    logic [PCW-1:0] poll_cnt_q, poll_cnt_d;
    logic [GCW-1:0] gap_cnt_q, gap_cnt_d;

    logic [1:0]  req_ready_q, req_ready_d;
    logic [1:0]  rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;
    logic        busy_q, busy_d;
    logic [31:0] m_data_in_q, m_data_in_d;
    logic [31:0] m_address_q, m_address_d;
    logic [7:0]  m_command_q, m_command_d;
    logic [2:0]  m_commtype_q, m_commtype_d;
    logic [6:0]  m_nmiso_bits_q, m_nmiso_bits_d;
    logic        m_validflag_q, m_validflag_d;

    logic        gnt;

    always_comb begin
        // NOTE: every variable gets a default first so no path can leave it unassigned and infer a latch.
        state_d        = state_q;
        prio_d         = prio_q;
        port_d         = port_q;
        cmd_d          = cmd_q;
        ctyp_d         = ctyp_q;
        addr_d         = addr_q;
        data_d         = data_q;
        nmiso_d        = nmiso_q;
        wren_d         = wren_q;
        poll_d         = poll_q;
        poll_cnt_d     = poll_cnt_q;
        gap_cnt_d      = gap_cnt_q;
        req_ready_d    = 2'b00;
        rsp_valid_d    = 2'b00;
        rsp_data_d     = rsp_data_q;
        rsp_err_d      = rsp_err_q;
        busy_d         = busy_q;
        m_data_in_d    = m_data_in_q;
        m_address_d    = m_address_q;
        m_command_d    = m_command_q;
        m_commtype_d   = m_commtype_q;
        m_nmiso_bits_d = m_nmiso_bits_q;
        m_validflag_d  = m_validflag_q;
        gnt            = 1'b0;

        case (state_q)
            IDLE: begin
                if (|bus.req_valid) begin
                    // Contention goes to the favoured port; a lone requester always wins.
                    gnt         = (bus.req_valid == 2'b11) ? prio_q : bus.req_valid[1];
                    port_d      = gnt;
                    prio_d      = ~gnt;
                    req_ready_d = gnt ? 2'b10 : 2'b01;
                    cmd_d       = gnt ? bus.req_cmd[15:8]    : bus.req_cmd[7:0];
                    ctyp_d      = gnt ? bus.req_ctyp[5:3]    : bus.req_ctyp[2:0];
                    addr_d      = gnt ? bus.req_addr[63:32]  : bus.req_addr[31:0];
                    data_d      = gnt ? bus.req_data[63:32]  : bus.req_data[31:0];
                    nmiso_d     = gnt ? bus.req_nmiso[13:7]  : bus.req_nmiso[6:0];
                    wren_d      = gnt ? bus.req_wren[1]      : bus.req_wren[0];
                    poll_d      = gnt ? bus.req_poll[1]      : bus.req_poll[0];
                    poll_cnt_d  = '0;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = GRANT;
                end
            end
            GRANT: state_d = wren_q ? WREN_ISS : CMD_ISS;
            WREN_ISS, CMD_ISS, POLL_ISS: begin
                // The master accepted once it drops tready; only then release validflag.
                if (m_validflag_q && !bus.m_tready) begin
                    m_validflag_d = 1'b0;
                    state_d       = (state_q == WREN_ISS) ? WREN_WT :
                                    (state_q == CMD_ISS)  ? CMD_WT  : POLL_WT;
                end else if (!m_validflag_q && bus.m_tready) begin
                    m_validflag_d = 1'b1;
                end
            end
            WREN_WT: begin
                if (bus.m_tready) state_d = CMD_ISS;
            end
            CMD_WT: begin
                if (bus.m_tready) begin
                    rsp_data_d = bus.m_data_out;
                    gap_cnt_d  = '0;
                    state_d    = poll_q ? GAP : RESP;
                end
            end
            GAP: begin
                if (gap_cnt_q == GCW'(POLL_GAP - 1)) begin
                    poll_cnt_d = poll_cnt_q + 1'b1;
                    state_d    = POLL_ISS;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            POLL_WT: begin
                if (bus.m_tready) begin
                    if (!bus.m_data_out[0]) begin
                        state_d = RESP;
                    end else if (poll_cnt_q == PCW'(MAX_POLLS)) begin
                        rsp_err_d = 1'b1;
                        state_d   = RESP;
                    end else begin
                        gap_cnt_d = '0;
                        state_d   = GAP;
                    end
                end
            end
            RESP: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // RESP lasts one cycle, so entering it yields exactly one rsp_valid pulse.
        if (state_d == RESP) rsp_valid_d = port_q ? 2'b10 : 2'b01;

        // Master fields are loaded on entry to an issue state and then held through its wait state.
        case (state_d)
            WREN_ISS: begin
                m_command_d    = WREN_OP;
                m_commtype_d   = WREN_CT;
                m_nmiso_bits_d = '0;
                m_address_d    = '0;
                m_data_in_d    = '0;
            end
            CMD_ISS: begin
                m_command_d    = cmd_q;
                m_commtype_d   = ctyp_q;
                m_nmiso_bits_d = nmiso_q;
                m_address_d    = addr_q;
                m_data_in_d    = data_q;
            end
            POLL_ISS: begin
                m_command_d    = RDSR_OP;
                m_commtype_d   = RDSR_CT;
                m_nmiso_bits_d = RDSR_NMISO;
                m_address_d    = '0;
                m_data_in_d    = '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            prio_q         <= 1'b0;
            port_q         <= 1'b0;
            cmd_q          <= '0;
            ctyp_q         <= '0;
            addr_q         <= '0;
            data_q         <= '0;
            nmiso_q        <= '0;
            wren_q         <= 1'b0;
            poll_q         <= 1'b0;
            poll_cnt_q     <= '0;
            gap_cnt_q      <= '0;
            req_ready_q    <= '0;
            rsp_valid_q    <= '0;
            rsp_data_q     <= '0;
            rsp_err_q      <= 1'b0;
            busy_q         <= 1'b0;
            m_data_in_q    <= '0;
            m_address_q    <= '0;
            m_command_q    <= '0;
            m_commtype_q   <= '0;
            m_nmiso_bits_q <= RST_NMISO;
            m_validflag_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of its _d.
            state_q        <= state_d;
            prio_q         <= prio_d;
            port_q         <= port_d;
            cmd_q          <= cmd_d;
            ctyp_q         <= ctyp_d;
            addr_q         <= addr_d;
            data_q         <= data_d;
            nmiso_q        <= nmiso_d;
            wren_q         <= wren_d;
            poll_q         <= poll_d;
            poll_cnt_q     <= poll_cnt_d;
            gap_cnt_q      <= gap_cnt_d;
            req_ready_q    <= req_ready_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_data_q     <= rsp_data_d;
            rsp_err_q      <= rsp_err_d;
            busy_q         <= busy_d;
            m_data_in_q    <= m_data_in_d;
            m_address_q    <= m_address_d;
            m_command_q    <= m_command_d;
            m_commtype_q   <= m_commtype_d;
            m_nmiso_bits_q <= m_nmiso_bits_d;
            m_validflag_q  <= m_validflag_d;
        end
    end

    assign bus.req_ready    = req_ready_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.rsp_err      = rsp_err_q;
    assign bus.busy         = busy_q;
    assign bus.m_data_in    = m_data_in_q;
    assign bus.m_address    = m_address_q;
    assign bus.m_command    = m_command_q;
    assign bus.m_commtype   = m_commtype_q;
    assign bus.m_nmiso_bits = m_nmiso_bits_q;
    assign bus.m_validflag  = m_validflag_q;

endmodule

// File: tb/tb_spi_fl_sequencer.sv
// Self-checking bench for spi_fl_sequencer: behavioural spi_master_fl model, transfer and
// response scoreboards, table-driven requests plus arbitration and mid-transfer reset sequences.
module tb_spi_fl_sequencer;

    localparam int MAX_POLLS = 4;
    localparam int POLL_GAP  = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_fl_sequencer_if bus ();

    spi_fl_sequencer #(.MAX_POLLS(MAX_POLLS), .POLL_GAP(POLL_GAP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // kind: 0 = WREN (cmd/ctyp), 1 = RDSR (+nmiso), 2 = main command (all fields)
    typedef struct {
        int          kind;
        logic [7:0]  cmd;
        logic [2:0]  ctyp;
        logic [6:0]  nmiso;
        logic [31:0] addr;
        logic [31:0] data;
    } xfer_t;

    typedef struct {
        logic [1:0]  valid;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    typedef struct {
        int          port;
        logic [7:0]  cmd;
        logic [2:0]  ctyp;
        logic [31:0] addr;
        logic [31:0] data;
        logic [6:0]  nmiso;
        bit          wren;
        bit          poll;
        logic [31:0] resp;
        int          nbusy;
        bit          stuck;
    } vec_t;

    xfer_t       exp_xfer_q[$];
    rsp_t        exp_rsp_q[$];
    logic [7:0]  stat_q[$];
    logic [7:0]  stat_default = 8'h00;
    logic [31:0] main_resp    = 32'h0;

    int errors = 0;
    int checks = 0;
    int vf_viol = 0;
    int vf_rises = 0;
    int captures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // spi_master_fl model: accepts on validflag while idle, busy 3 cycles, then returns data.
    initial begin : master_model
        int          busy_cnt;
        logic [31:0] pend;
        xfer_t       e;
        busy_cnt = 0;
        pend = '0;
        bus.m_tready   = 1'b1;
        bus.m_data_out = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bus.m_tready = 1'b1;
                busy_cnt = 0;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    bus.m_data_out = pend;
                    bus.m_tready   = 1'b1;
                end
            end else if (bus.m_tready && bus.m_validflag) begin
                captures++;
                check("xfer_expected", exp_xfer_q.size() != 0, 1'b1);
                if (exp_xfer_q.size() != 0) begin
                    e = exp_xfer_q.pop_front();
                    check("xfer_cmd_ctyp", {bus.m_command, bus.m_commtype}, {e.cmd, e.ctyp});
                    if (e.kind >= 1) check("xfer_nmiso", bus.m_nmiso_bits, e.nmiso);
                    if (e.kind == 2) check("xfer_addr_data", {bus.m_address, bus.m_data_in}, {e.addr, e.data});
                end
                if (bus.m_command == 8'h05)
                    pend = {24'h0, (stat_q.size() != 0) ? stat_q.pop_front() : stat_default};
                else
                    pend = main_resp;
                bus.m_tready = 1'b0;
                busy_cnt = 3;
            end
        end
    end

    // validflag protocol: rises only while tready=1, falls on the edge that sees tready=0.
    initial begin : vf_monitor
        logic prev_vf;
        prev_vf = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                prev_vf = 1'b0;
            end else begin
                if (!prev_vf && bus.m_validflag) begin
                    vf_rises++;
                    if (!bus.m_tready) vf_viol++;
                end
                if (prev_vf && bus.m_validflag && !bus.m_tready) vf_viol++;
                prev_vf = bus.m_validflag;
            end
        end
    end

    initial begin : rsp_monitor
        rsp_t r;
        forever begin
            @(negedge clk);
            if (rst_n && bus.rsp_valid != 2'b00) begin
                check("rsp_expected", exp_rsp_q.size() != 0, 1'b1);
                if (exp_rsp_q.size() != 0) begin
                    r = exp_rsp_q.pop_front();
                    check("rsp_valid", bus.rsp_valid, r.valid);
                    check("rsp_data", bus.rsp_data, r.data);
                    check("rsp_err", bus.rsp_err, r.err);
                end
            end
        end
    end

    task automatic check_reset_vals(input string name);
        check(name,
              {bus.req_ready, bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.busy, bus.m_data_in,
               bus.m_address, bus.m_command, bus.m_commtype, bus.m_nmiso_bits, bus.m_validflag},
              {2'b00, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 8'h00, 3'b000, 7'd32, 1'b0});
    endtask

    task automatic set_fields(input vec_t v);
        bus.req_cmd[8*v.port +: 8]    = v.cmd;
        bus.req_ctyp[3*v.port +: 3]   = v.ctyp;
        bus.req_addr[32*v.port +: 32] = v.addr;
        bus.req_data[32*v.port +: 32] = v.data;
        bus.req_nmiso[7*v.port +: 7]  = v.nmiso;
        bus.req_wren[v.port]          = v.wren;
        bus.req_poll[v.port]          = v.poll;
    endtask

    task automatic push_main(input vec_t v);
        xfer_t x;
        x = '{kind: 2, cmd: v.cmd, ctyp: v.ctyp, nmiso: v.nmiso, addr: v.addr, data: v.data};
        exp_xfer_q.push_back(x);
    endtask

    task automatic wait_ready(output logic [1:0] r);
        r = 2'b00;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.req_ready != 2'b00) begin
                r = bus.req_ready;
                return;
            end
        end
    endtask

    task automatic do_req(input vec_t v);
        logic [1:0] r;
        @(negedge clk);
        set_fields(v);
        bus.req_valid[v.port] = 1'b1;
        wait_ready(r);
        check("req_ready", r, (v.port == 1) ? 2'b10 : 2'b01);
        check("busy_at_grant", bus.busy, 1'b1);
        bus.req_valid[v.port] = 1'b0;
    endtask

    task automatic wait_rsp();
        for (int i = 0; i < 3000; i++) begin
            if (exp_rsp_q.size() == 0) break;
            @(negedge clk);
        end
        check("rsp_timeout", exp_rsp_q.size(), 0);
        exp_rsp_q.delete();
    endtask

    vec_t vecs[6];

    initial begin : main_seq
        logic [1:0] r;
        vec_t       a0, a1;
        xfer_t      x;
        int         npoll;
        bit         found;

        // port, cmd, ctyp, addr, data, nmiso, wren, poll, resp, nbusy, stuck
        vecs[0] = '{0, 8'h9F, 3'b001, 32'h0,        32'h0,        7'd24, 0, 0, 32'h00C22018, 0, 0};
        vecs[1] = '{1, 8'h02, 3'b100, 32'h00001000, 32'hDEADBEEF, 7'd0,  1, 1, 32'h12345678, 2, 0};
        vecs[2] = '{0, 8'h20, 3'b010, 32'h00ABC000, 32'h0,        7'd0,  1, 1, 32'h0000_0000, 0, 0};
        vecs[3] = '{1, 8'h03, 3'b011, 32'h00000040, 32'h0,        7'd32, 0, 0, 32'hA5A55A5A, 0, 0};
        vecs[4] = '{0, 8'hD8, 3'b010, 32'h00010000, 32'h0,        7'd0,  1, 1, 32'h0BADF00D, 0, 1};
        vecs[5] = '{1, 8'h60, 3'b000, 32'h0,        32'h0,        7'd0,  0, 1, 32'h00000077, 3, 0};

        bus.req_valid = '0; bus.req_cmd = '0; bus.req_ctyp = '0; bus.req_addr = '0;
        bus.req_data = '0; bus.req_nmiso = '0; bus.req_wren = '0; bus.req_poll = '0;

        repeat (3) @(negedge clk);
        check_reset_vals("reset_values");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_vals("idle_after_release");

        // Round robin: both request, port0 re-requests after its grant.
        a0 = '{0, 8'h9F, 3'b001, 32'h0, 32'h0, 7'd24, 0, 0, 32'h0, 0, 0};
        a1 = '{1, 8'h4B, 3'b011, 32'h100, 32'h0, 7'd16, 0, 0, 32'h0, 0, 0};
        main_resp = 32'h1111_2222;
        push_main(a0); push_main(a1); push_main(a0);
        exp_rsp_q.push_back('{2'b01, 32'h1111_2222, 1'b0});
        exp_rsp_q.push_back('{2'b10, 32'h1111_2222, 1'b0});
        exp_rsp_q.push_back('{2'b01, 32'h1111_2222, 1'b0});
        @(negedge clk);
        set_fields(a0);
        set_fields(a1);
        bus.req_valid = 2'b11;
        wait_ready(r);
        check("arb_first", r, 2'b01);
        wait_ready(r);
        check("arb_second", r, 2'b10);
        bus.req_valid[1] = 1'b0;
        wait_ready(r);
        check("arb_third", r, 2'b01);
        bus.req_valid[0] = 1'b0;
        wait_rsp();

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].wren) begin
                x = '{kind: 0, cmd: 8'h06, ctyp: 3'b000, nmiso: 7'd0, addr: 32'h0, data: 32'h0};
                exp_xfer_q.push_back(x);
            end
            push_main(vecs[i]);
            npoll = 0;
            if (vecs[i].poll) npoll = vecs[i].stuck ? MAX_POLLS : vecs[i].nbusy + 1;
            for (int k = 0; k < npoll; k++) begin
                x = '{kind: 1, cmd: 8'h05, ctyp: 3'b001, nmiso: 7'd8, addr: 32'h0, data: 32'h0};
                exp_xfer_q.push_back(x);
            end
            for (int k = 0; k < vecs[i].nbusy; k++) stat_q.push_back(8'h03);
            if (vecs[i].poll && !vecs[i].stuck) stat_q.push_back(8'h00);
            stat_default = vecs[i].stuck ? 8'h01 : 8'h00;
            main_resp = vecs[i].resp;
            exp_rsp_q.push_back('{(vecs[i].port == 1) ? 2'b10 : 2'b01, vecs[i].resp, vecs[i].stuck});
            do_req(vecs[i]);
            wait_rsp();
            repeat (3) @(negedge clk);
            check("rsp_hold", {bus.rsp_data, bus.rsp_err}, {vecs[i].resp, vecs[i].stuck});
            check("busy_idle", bus.busy, 1'b0);
            check("xfer_count", exp_xfer_q.size(), 0);
            stat_default = 8'h00;
            stat_q.delete();
        end

        // Reset while the main command is in flight.
        main_resp = 32'h5555_AAAA;
        push_main(vecs[0]);
        do_req(vecs[0]);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!bus.m_tready && !bus.m_validflag && bus.m_command == 8'h9F) begin
                found = 1'b1;
                break;
            end
        end
        check("reached_cmd_wt", found, 1'b1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset_vals("reset_mid_transfer");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_xfer_q.delete();
        push_main(vecs[0]);
        main_resp = 32'h00C22018;
        exp_rsp_q.push_back('{2'b01, 32'h00C22018, 1'b0});
        do_req(vecs[0]);
        wait_rsp();

        repeat (5) @(negedge clk);
        check("xfer_leftover", exp_xfer_q.size(), 0);
        check("validflag_protocol", vf_viol, 0);
        check("validflag_rises", vf_rises, captures);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
